// File: rtl/fg_pkg.sv
// Shared constants and types for the Block Party solver.
//   ROWS / LANES : map geometry (64 rows, 8 lanes; LANES is fixed)
//   move_e       : move encodings driven on `out`
//   cell_e       : per-lane cell codes on in0..in7
//   state_e      : solver FSM states
//   row_info_t   : compressed per-row record kept in the obstacle store
//   apply_move   : lane update for a move, saturating at the outer lanes
package fg_pkg;

  localparam int unsigned ROWS  = 64;
  localparam int unsigned LANES = 8;
  localparam int unsigned RowW  = $clog2(ROWS);
  localparam int unsigned LaneW = $clog2(LANES);

  typedef enum logic [1:0] {
    MV_STOP  = 2'd0,
    MV_RIGHT = 2'd1,
    MV_LEFT  = 2'd2,
    MV_JUMP  = 2'd3
  } move_e;

  typedef enum logic [1:0] {
    ROAD  = 2'd0,
    LOW   = 2'd1,
    HIGH  = 2'd2,
    TRAIN = 2'd3
  } cell_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StOut  = 2'd2
  } state_e;

  // An obstacle row is seven trains plus one passable gap, so a flag, the gap
  // lane and the gap cell type describe it completely.
  typedef struct packed {
    logic             obstacle;
    logic [LaneW-1:0] gap_lane;
    logic [1:0]       gap_type;
  } row_info_t;

  function automatic logic [LaneW-1:0] apply_move(input logic [LaneW-1:0] lane,
                                                  input logic [1:0]       mv);
    logic [LaneW-1:0] res;
    res = lane;
    if (mv == MV_RIGHT && lane != LaneW'(LANES - 1)) begin
      res = lane + LaneW'(1);
    end else if (mv == MV_LEFT && lane != '0) begin
      res = lane - LaneW'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/fg_block_solver_if.sv
// Pattern-side bus of the solver.
//   in_valid, guy, in0..in7 : map stream from the pattern (master drives)
//   out_valid, out          : move stream back to the pattern (slave drives)
interface fg_block_solver_if;
  import fg_pkg::*;

  logic             in_valid;
  logic [LaneW-1:0] guy;
  logic [1:0]       in0;
  logic [1:0]       in1;
  logic [1:0]       in2;
  logic [1:0]       in3;
  logic [1:0]       in4;
  logic [1:0]       in5;
  logic [1:0]       in6;
  logic [1:0]       in7;
  logic             out_valid;
  logic [1:0]       out;

  modport master (
    output in_valid, guy, in0, in1, in2, in3, in4, in5, in6, in7,
    input  out_valid, out
  );

  modport slave (
    input  in_valid, guy, in0, in1, in2, in3, in4, in5, in6, in7,
    output out_valid, out
  );

endinterface

// File: rtl/fg_row_decode.sv
// Combinational row classifier.
//   in0..in7 : cell codes of one map row
//   obstacle : row contains trains (otherwise it is all road)
//   gap_lane : lowest lane that is not a train
//   gap_type : cell code found in that gap lane
// An all-road row reports obstacle=0, gap_lane=0, gap_type=ROAD.
module fg_row_decode
  import fg_pkg::*;
(
  input  logic [1:0]       in0,
  input  logic [1:0]       in1,
  input  logic [1:0]       in2,
  input  logic [1:0]       in3,
  input  logic [1:0]       in4,
  input  logic [1:0]       in5,
  input  logic [1:0]       in6,
  input  logic [1:0]       in7,
  output logic             obstacle,
  output logic [LaneW-1:0] gap_lane,
  output logic [1:0]       gap_type
);

  logic [LANES-1:0][1:0] cells;
  logic                  found;

  assign cells = {in7, in6, in5, in4, in3, in2, in1, in0};

  always_comb begin
    obstacle = 1'b0;
    gap_lane = '0;
    gap_type = ROAD;
    found    = 1'b0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (cells[i] == TRAIN) begin
        obstacle = 1'b1;
      end else if (!found) begin
        found    = 1'b1;
        gap_lane = LaneW'(i);
        gap_type = cells[i];
      end
    end
  end

endmodule

// File: rtl/fg_block_solver.sv
// Block Party game core: loads one 64-row map, then streams 63 moves that take
// the guy from row 0 to row 63 without colliding.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : slave side of fg_block_solver_if (map in, moves out)
// Each load cycle writes a compressed row record; each output cycle drives the
// move for row k->k+1 while the planner prepares the move for the next cycle.
module fg_block_solver
  import fg_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  fg_block_solver_if.slave   bus
);

  state_e           state_q;
  logic [RowW-1:0]  row_q;       // load row index, then output cycle index k
  logic [LaneW-1:0] lane_q;      // lane before the move currently on out_q
  logic             out_valid_q;
  logic [1:0]       out_q;
  row_info_t        store_q [ROWS];

  logic             dec_obstacle;
  logic [LaneW-1:0] dec_gap_lane;
  logic [1:0]       dec_gap_type;

  fg_row_decode u_row_decode (
    .in0      (bus.in0),
    .in1      (bus.in1),
    .in2      (bus.in2),
    .in3      (bus.in3),
    .in4      (bus.in4),
    .in5      (bus.in5),
    .in6      (bus.in6),
    .in7      (bus.in7),
    .obstacle (dec_obstacle),
    .gap_lane (dec_gap_lane),
    .gap_type (dec_gap_type)
  );

  // Row 0 is road by definition, so whatever arrives on it is not stored.
  logic      wr_en;
  row_info_t wr_info;

  always_comb begin
    wr_en   = bus.in_valid && (state_q == StIdle || state_q == StLoad);
    wr_info = '0;
    if (state_q == StLoad) begin
      wr_info.obstacle = dec_obstacle;
      wr_info.gap_lane = dec_gap_lane;
      wr_info.gap_type = dec_gap_type;
    end
  end

  // The first move is planned on the same edge that writes row 63, so the row
  // being written is forwarded into the planner's view of the store.
  row_info_t eff [ROWS];

  always_comb begin
    for (int i = 0; i < int'(ROWS); i++) begin
      eff[i] = store_q[i];
      if (wr_en && row_q == RowW'(i)) begin
        eff[i] = wr_info;
      end
    end
  end

  // Planner inputs: in LOAD it prepares cycle 0 from the start lane; in OUT it
  // prepares cycle k+1 from the lane reached after the current move.
  logic [LaneW-1:0] lane_next;
  logic [RowW-1:0]  plan_k;
  logic [LaneW-1:0] plan_p;

  always_comb begin
    lane_next = apply_move(lane_q, out_q);
    plan_k    = '0;
    plan_p    = lane_q;
    if (state_q == StOut) begin
      plan_k = row_q + RowW'(1);
      plan_p = lane_next;
    end
  end

  // Next obstacle row strictly after plan_k; descending scan keeps the lowest.
  logic            nxt_found;
  logic [RowW-1:0] nxt_row;
  row_info_t       nxt_info;
  move_e           plan_mv;

  always_comb begin
    nxt_found = 1'b0;
    nxt_row   = '0;
    for (int i = int'(ROWS) - 1; i >= 0; i--) begin
      if (RowW'(i) > plan_k && eff[i].obstacle) begin
        nxt_found = 1'b1;
        nxt_row   = RowW'(i);
      end
    end
    nxt_info = eff[nxt_row];

    plan_mv = MV_STOP;
    if (nxt_found) begin
      if (plan_p < nxt_info.gap_lane) begin
        plan_mv = MV_RIGHT;
      end else if (plan_p > nxt_info.gap_lane) begin
        plan_mv = MV_LEFT;
      end else if (nxt_row == plan_k + RowW'(1) && nxt_info.gap_type == LOW) begin
        plan_mv = MV_JUMP;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      row_q       <= '0;
      lane_q      <= '0;
      out_valid_q <= 1'b0;
      out_q       <= MV_STOP;
      for (int i = 0; i < int'(ROWS); i++) begin
        store_q[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        store_q[row_q] <= wr_info;
      end
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            state_q <= StLoad;
            row_q   <= RowW'(1);
            lane_q  <= bus.guy;
          end
        end
        StLoad: begin
          if (bus.in_valid) begin
            if (row_q == RowW'(ROWS - 1)) begin
              state_q     <= StOut;
              row_q       <= '0;
              out_valid_q <= 1'b1;
              out_q       <= plan_mv;
            end else begin
              row_q <= row_q + RowW'(1);
            end
          end
        end
        StOut: begin
          if (row_q == RowW'(ROWS - 2)) begin
            state_q     <= StIdle;
            row_q       <= '0;
            lane_q      <= '0;
            out_valid_q <= 1'b0;
            out_q       <= MV_STOP;
          end else begin
            row_q  <= row_q + RowW'(1);
            lane_q <= lane_next;
            out_q  <= plan_mv;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_valid_q ? out_q : 2'(MV_STOP);

endmodule

// File: tb/tb_fg_block_solver.sv
// Directed bench for fg_block_solver: a table of maps with hand-derived move
// sequences, plus a mid-output reset and a back-to-back pattern sequence.
module tb_fg_block_solver;
  import fg_pkg::*;

  typedef struct packed {
    logic [2:0]      guy;
    logic [5:0]      r1;
    logic [2:0]      g1;
    logic [1:0]      t1;
    logic [5:0]      r2;
    logic [2:0]      g2;
    logic [1:0]      t2;
    logic [4:0][5:0] seg_end;  // move seg_mv[i] holds for k up to seg_end[i]
    logic [4:0][1:0] seg_mv;
  } vec_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  vec_t vecs [6];

  fg_block_solver_if bus ();

  fg_block_solver dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input int guy, input int r1, input int g1, input int t1,
                              input int r2, input int g2, input int t2,
                              input int e0, input int m0, input int e1, input int m1,
                              input int e2, input int m2, input int e3, input int m3,
                              input int e4, input int m4);
    vec_t v;
    v.guy = 3'(guy);
    v.r1  = 6'(r1);
    v.g1  = 3'(g1);
    v.t1  = 2'(t1);
    v.r2  = 6'(r2);
    v.g2  = 3'(g2);
    v.t2  = 2'(t2);
    v.seg_end[0] = 6'(e0);
    v.seg_mv[0]  = 2'(m0);
    v.seg_end[1] = 6'(e1);
    v.seg_mv[1]  = 2'(m1);
    v.seg_end[2] = 6'(e2);
    v.seg_mv[2]  = 2'(m2);
    v.seg_end[3] = 6'(e3);
    v.seg_mv[3]  = 2'(m3);
    v.seg_end[4] = 6'(e4);
    v.seg_mv[4]  = 2'(m4);
    return v;
  endfunction

  function automatic logic [1:0] exp_move(input vec_t v, input int k);
    logic [1:0] mv;
    logic       hit;
    mv  = 2'd0;
    hit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (!hit && k <= int'(v.seg_end[i])) begin
        hit = 1'b1;
        mv  = v.seg_mv[i];
      end
    end
    return mv;
  endfunction

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  task automatic drive_row(input vec_t v, input int r);
    logic [1:0] c [8];
    for (int i = 0; i < 8; i++) c[i] = 2'd0;
    if (r != 0 && r == int'(v.r1)) begin
      for (int i = 0; i < 8; i++) c[i] = 2'd3;
      c[v.g1] = v.t1;
    end
    if (r != 0 && r == int'(v.r2)) begin
      for (int i = 0; i < 8; i++) c[i] = 2'd3;
      c[v.g2] = v.t2;
    end
    bus.in0 = c[0];
    bus.in1 = c[1];
    bus.in2 = c[2];
    bus.in3 = c[3];
    bus.in4 = c[4];
    bus.in5 = c[5];
    bus.in6 = c[6];
    bus.in7 = c[7];
  endtask

  task automatic idle(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("%s idle out_valid/out", name), int'({bus.out_valid, bus.out}), 0);
    end
  endtask

  // Streams one map, then checks all 63 output cycles. abort_at >= 0 pulses
  // reset during that output cycle and returns early.
  task automatic run(input vec_t v, input string name, input int abort_at);
    for (int r = 0; r < 64; r++) begin
      @(negedge clk);
      check($sformatf("%s load r%0d out_valid/out", name, r),
            int'({bus.out_valid, bus.out}), 0);
      drive_row(v, r);
      bus.in_valid = 1'b1;
      // guy must only be taken from the first row cycle
      bus.guy = (r == 0) ? v.guy : ~v.guy;
    end
    for (int k = 0; k < 63; k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus.in_valid = 1'b0;
        drive_row(v, 0);
      end
      check($sformatf("%s k%0d out_valid", name, k), int'(bus.out_valid), 1);
      check($sformatf("%s k%0d out", name, k), int'(bus.out), int'(exp_move(v, k)));
      if (k == abort_at) begin
        #2 rst_n = 1'b0;
        #1 check($sformatf("%s async reset drop", name), int'({bus.out_valid, bus.out}), 0);
        @(negedge clk);
        check($sformatf("%s held in reset", name), int'({bus.out_valid, bus.out}), 0);
        rst_n = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    clk          = 1'b0;
    rst_n        = 1'b0;
    total        = 0;
    bad          = 0;
    bus.in_valid = 1'b0;
    bus.guy      = 3'd0;
    drive_row(mk(0, 0, 0, 0, 0, 0, 0, 62, 0, 62, 0, 62, 0, 62, 0, 62, 0), 0);

    //          guy r1 g1 t1 r2 g2 t2   segments (end k, move)
    vecs[0] = mk(5,  0, 0, 0,  0, 0, 0,  62, 0, 62, 0, 62, 0, 62, 0, 62, 0);
    vecs[1] = mk(0, 10, 3, 0,  0, 0, 0,   2, 1, 62, 0, 62, 0, 62, 0, 62, 0);
    vecs[2] = mk(4,  2, 4, 1,  0, 0, 0,   0, 0,  1, 3, 62, 0, 62, 0, 62, 0);
    vecs[3] = mk(7,  8, 2, 2, 12, 5, 1,   4, 2,  7, 0, 10, 1, 11, 3, 62, 0);
    vecs[4] = mk(3,  1, 3, 1,  5, 0, 0,   0, 3,  3, 2, 62, 0, 62, 0, 62, 0);
    vecs[5] = mk(0, 63, 7, 1,  0, 0, 0,   6, 1, 61, 0, 62, 3, 62, 0, 62, 0);

    repeat (3) @(negedge clk);
    check("reset out_valid/out", int'({bus.out_valid, bus.out}), 0);
    rst_n = 1'b1;
    idle(2, "post_reset");

    for (int i = 0; i < 6; i++) begin
      run(vecs[i], $sformatf("vec%0d", i), -1);
      idle(3, $sformatf("vec%0d", i));
    end

    // Reset during output cycle 20, then a fresh pattern must match standalone.
    run(vecs[3], "rst_mid", 20);
    idle(2, "rst_mid");
    run(vecs[2], "after_rst", -1);
    idle(2, "after_rst");

    // Second pattern starts the cycle right after out_valid falls.
    run(vecs[3], "b2b_first", -1);
    run(vecs[1], "b2b_second", -1);
    idle(2, "b2b_second");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
